// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver with majority-vote
// bit sampling, optional parity, 1/2 stop bits, break detection and a
// valid/ready holding register carrying per-word error flags.
module uart_rx_param #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int unsigned SAMPLE_HZ = BAUD * OVERSAMPLE;
  localparam int unsigned DIV       = (CLK_HZ + SAMPLE_HZ / 2) / SAMPLE_HZ;
  localparam int unsigned DW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW        = $clog2(OVERSAMPLE);
  localparam int unsigned CW        = $clog2(DATA_BITS + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] SC_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SC_S0    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_S1    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SC_MID   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CNT_DATA = CW'(DATA_BITS);
  localparam logic [CW-1:0] CNT_STOP = CW'(STOP_BITS - 1);
  localparam logic          ODD_MODE = (PARITY == 1);

  if (DIV < 1) begin : g_chk_div
    $error("uart_rx_param: DIV < 1, CLK_HZ too low for BAUD*OVERSAMPLE");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_chk_os
    $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_chk_db
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_chk_par
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_chk_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   rxs_q, rxs_d;
  logic                   rxs_prev_q, rxs_prev_d;
  logic [DW-1:0]          div_q, div_d;
  logic [SW-1:0]          sc_q, sc_d;
  logic                   s0_q, s0_d;
  logic                   s1_q, s1_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   perr_acc_q, perr_acc_d;
  logic                   ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  logic tick, mid, end_bit, maj, done, done_ferr, accept;

  assign tick    = (div_q == DIV_LAST);
  assign mid     = tick && (sc_q == SC_MID);
  assign end_bit = tick && (sc_q == SC_LAST);
  assign maj     = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  assign accept  = valid_q & rx_ready;

  // Synchroniser, baud divider, sample counter and receive FSM next state.
  always_comb begin
    sync1_d    = rx_in;
    rxs_d      = sync1_q;
    rxs_prev_d = rxs_q;
    state_d    = state_q;
    div_d      = div_q;
    sc_d       = sc_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    done       = 1'b0;
    done_ferr  = 1'b0;

    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        sc_d = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
        if (sc_q == SC_S0) s0_d = rxs_q;
        if (sc_q == SC_S1) s1_d = rxs_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        sc_d  = '0;
        cnt_d = '0;
        if (rxs_prev_q && !rxs_q) begin
          state_d    = S_START;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      S_START: begin
        if (mid && maj) begin
          state_d = S_IDLE;
        end else if (end_bit) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (mid) begin
          shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
        end else if (end_bit && (cnt_q == CNT_DATA)) begin
          cnt_d   = '0;
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (mid) begin
          perr_acc_d = (^shreg_q) ^ maj ^ ODD_MODE;
        end else if (end_bit) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Frame completes at the last stop-bit mid-point so a back-to-back
        // start edge in the following half bit is still seen from IDLE.
        if (mid) begin
          if (!maj) ferr_acc_d = 1'b1;
          if (cnt_q == CNT_STOP) begin
            done      = 1'b1;
            done_ferr = ferr_acc_q | ~maj;
            state_d   = ((shreg_q == '0) && done_ferr) ? S_BREAK : S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: load on completion unless a held word is not being taken.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done) begin
      if (!valid_q || accept) begin
        data_d  = shreg_q;
        perr_d  = perr_acc_q;
        ferr_d  = done_ferr;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State registers, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      div_q      <= '0;
      sc_q       <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      cnt_q      <= '0;
      shreg_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rxs_q      <= rxs_d;
      rxs_prev_q <= rxs_prev_d;
      div_q      <= div_d;
      sc_q       <= sc_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
  assign rx_busy     = (state_q != S_IDLE);

endmodule
